// File: rtl/oclib_apb_to_regs.sv
// APB slave exposing NumRegs 32-bit registers; optional LOCK on reg 0
// (macro OCLIB_APB_TO_REGS_LOCK_EN). Ports: clock, reset, apb, apbFb, regOut.
package oclib_pkg;
  localparam bit True  = 1'b1;
  localparam bit False = 1'b0;

  typedef struct packed {
    logic        select;
    logic        enable;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } apb_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } apb_fb_s;
endpackage

module oclib_apb_to_regs #(
  parameter type         ApbType       = oclib_pkg::apb_s,
  parameter type         ApbFbType     = oclib_pkg::apb_fb_s,
  parameter int          NumRegs       = 8,
  parameter int          WaitStates    = 0,
  parameter bit          ApbSlaveError = oclib_pkg::True,
  parameter logic [31:0] ResetValue    = 32'h0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  ApbType                  apb,
  output ApbFbType                apbFb,
  output logic [NumRegs*32-1:0]   regOut
);

  localparam int IdxW = $clog2(NumRegs);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  ApbFbType    fb_q, fb_d;
  logic [31:0] regs_q [NumRegs];
  logic [31:0] regs_d [NumRegs];

  logic            req;
  logic [IdxW-1:0] idx;
  logic            hi_set;
  logic            in_range;
  logic            locked;
  logic            go;
  logic [31:0]     rd_val;

  assign req    = apb.select && apb.enable;
  assign idx    = apb.address[IdxW+1:2];
  assign hi_set = |(apb.address >> (IdxW + 2));

  // Non power-of-two counts leave holes at the top of the index space.
  assign in_range = !hi_set &&
                    ({1'b0, idx} < (IdxW+1)'(NumRegs));

`ifdef OCLIB_APB_TO_REGS_LOCK_EN
  assign locked = regs_q[0][0] && (idx != '0);
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (IdxW'(i) == idx) rd_val = regs_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fb_d    = '0;
    regs_d  = regs_q;
    go      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d = 4'(WaitStates);
          if (WaitStates > 0) begin
            state_d = StWait;
          end else begin
            state_d = StResp;
            go      = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          cnt_d   = '0;
          go      = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StDone;
      StDone: if (!req) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Response and write commit share the edge that enters StResp.
    if (go) begin
      fb_d.ready = 1'b1;
      if (apb.write) begin
        if (in_range && !locked) begin
          for (int i = 0; i < NumRegs; i++) begin
            if (IdxW'(i) == idx) regs_d[i] = apb.wdata;
          end
        end else begin
          fb_d.error = ApbSlaveError;
        end
      end else if (in_range) begin
        fb_d.rdata = rd_val;
      end else begin
        fb_d.error = ApbSlaveError;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fb_q    <= '0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= ResetValue;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fb_q    <= fb_d;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign apbFb = fb_q;

  for (genvar g = 0; g < NumRegs; g++) begin : g_out
    assign regOut[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_oclib_apb_to_regs.sv
// Randomized bench for oclib_apb_to_regs: three instances with different
// wait states / error modes checked against an array reference model.
module tb_oclib_apb_to_regs;
  import oclib_pkg::*;

  localparam int          W0 = 0, W1 = 3, W2 = 5;
  localparam bit          E0 = True, E1 = False, E2 = True;
  localparam logic [31:0] R0 = 32'h0, R1 = 32'h0, R2 = 32'hA5A5_0000;

  logic    clk = 1'b0;
  logic    rst;
  apb_s    apb [3];
  apb_fb_s fb  [3];
  logic [255:0] ro [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mreg [3][8];

  always #5 clk = ~clk;

  oclib_apb_to_regs #(.NumRegs(8), .WaitStates(W0),
    .ApbSlaveError(E0), .ResetValue(R0)) u_d0 (
    .clock(clk), .reset(rst), .apb(apb[0]),
    .apbFb(fb[0]), .regOut(ro[0]));

  oclib_apb_to_regs #(.NumRegs(8), .WaitStates(W1),
    .ApbSlaveError(E1), .ResetValue(R1)) u_d1 (
    .clock(clk), .reset(rst), .apb(apb[1]),
    .apbFb(fb[1]), .regOut(ro[1]));

  oclib_apb_to_regs #(.NumRegs(8), .WaitStates(W2),
    .ApbSlaveError(E2), .ResetValue(R2)) u_d2 (
    .clock(clk), .reset(rst), .apb(apb[2]),
    .apbFb(fb[2]), .regOut(ro[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? W0 : ((d == 1) ? W1 : W2);
  endfunction

  function automatic bit err_of(input int d);
    return (d == 0) ? E0 : ((d == 1) ? E1 : E2);
  endfunction

  function automatic logic [31:0] rv_of(input int d);
    return (d == 0) ? R0 : ((d == 1) ? R1 : R2);
  endfunction

  function automatic logic [255:0] mvec(input int d);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = mreg[d][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++) mreg[d][i] = rv_of(d);
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int d, input bit wr,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input int hold);
    logic [31:0] er;
    logic        ee;
    int          idx;
    bit          oor;
    bit          blk;
    int          k;
    idx = int'(addr[4:2]);
    oor = |addr[31:5];
    blk = 1'b0;
`ifdef OCLIB_APB_TO_REGS_LOCK_EN
    blk = wr && (idx != 0) && mreg[d][0][0];
`endif
    if (wr) begin
      er = '0;
      ee = (oor || blk) && err_of(d);
    end else begin
      er = oor ? 32'h0 : mreg[d][idx];
      ee = oor && err_of(d);
    end
    @(negedge clk);
    apb[d] = '{select: 1'b1, enable: 1'b0, write: wr,
               address: addr, wdata: wd};
    @(negedge clk);
    chk("setup_idle", {fb[d].ready, fb[d].error, fb[d].rdata}, '0);
    apb[d].enable = 1'b1;
    k = 0;
    while (k <= 40) begin
      @(posedge clk);
      #1;
      if (fb[d].ready) break;
      k++;
    end
    chk("latency", k, ws_of(d));
    chk("rdata", fb[d].rdata, er);
    chk("error", fb[d].error, ee);
    if (wr && !oor && !blk) mreg[d][idx] = wd;
    @(posedge clk);
    #1;
    chk("pulse_end", {fb[d].ready, fb[d].error, fb[d].rdata}, '0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("held_no_rdy", fb[d].ready, 1'b0);
    end
    chk("regout", ro[d], mvec(d));
    @(negedge clk);
    apb[d] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    int          d;
    for (int i = 0; i < 3; i++) apb[i] = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_fb", fb[i], '0);
      chk("rst_regs", ro[i], mvec(i));
    end
    @(negedge clk);
    rst = 1'b0;

    xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 0);
    xfer(0, 1'b0, 32'h8, 32'h0, 0);
    chk("reg2_word", ro[0][95:64], 32'hDEAD_BEEF);
    xfer(1, 1'b1, 32'h4, 32'h0BAD_F00D, 0);
    xfer(1, 1'b0, 32'h4, 32'h0, 0);
    xfer(0, 1'b1, 32'h20, 32'h1234, 0);
    xfer(1, 1'b1, 32'h20, 32'h1234, 0);
    xfer(2, 1'b0, 32'h8000_0000, 32'h0, 0);
    xfer(0, 1'b1, 32'hF, 32'h7777_0001, 4);
    xfer(2, 1'b1, 32'h1C, 32'h1111_2222, 4);

`ifdef OCLIB_APB_TO_REGS_LOCK_EN
    xfer(0, 1'b1, 32'h0, 32'h1, 0);
    xfer(0, 1'b1, 32'h4, 32'h55, 0);
    xfer(0, 1'b1, 32'h0, 32'h0, 0);
    xfer(0, 1'b1, 32'h4, 32'h55, 0);
    chk("lock_reg1", ro[0][63:32], 32'h55);
`endif

    for (int n = 0; n < 150; n++) begin
      d  = int'($urandom_range(0, 2));
      a  = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0)
        a = a | (32'h1 << $urandom_range(5, 31));
      wd = $urandom;
      xfer(d, 1'($urandom_range(0, 1)), a, wd,
           int'($urandom_range(0, 3)));
    end

    xfer(2, 1'b1, 32'h0, 32'hCAFE_0000, 0);
    @(negedge clk);
    apb[2] = '{select: 1'b1, enable: 1'b0, write: 1'b1,
               address: 32'h0, wdata: 32'h1357_9BDF};
    @(negedge clk);
    apb[2].enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_rst_fb", fb[i], '0);
      chk("async_rst_regs", ro[i], mvec(i));
    end
    @(negedge clk);
    apb[2] = '0;
    @(negedge clk);
    rst = 1'b0;
    xfer(2, 1'b0, 32'h0, 32'h0, 0);
    xfer(0, 1'b0, 32'h8, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
